// File: rtl/register_file_pkg.sv
// Shared datapath constants: default widths and named architectural registers.
package register_file_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_NREG   = 2 ** DEF_ADDR_W;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_AT   = 5'd1;
    localparam logic [4:0] REG_V0   = 5'd2;
    localparam logic [4:0] REG_T1   = 5'd9;
    localparam logic [4:0] REG_SP   = 5'd29;
    localparam logic [4:0] REG_RA   = 5'd31;

    typedef logic [DEF_DATA_W-1:0] word_t;

endpackage

// File: rtl/register_file_if.sv
// Write-back and operand-read bundle between the datapath and the register file.
interface register_file_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              reg_write;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [ADDR_W-1:0] raddr1;
    logic [ADDR_W-1:0] raddr2;
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;

    modport master (
        output reg_write, waddr, wdata, raddr1, raddr2,
        input  rdata1, rdata2
    );

    modport slave (
        input  reg_write, waddr, wdata, raddr1, raddr2,
        output rdata1, rdata2
    );
endinterface

// File: rtl/register_file_write_decoder.sv
// Enabled binary-to-one-hot write decoder; entry 0 ($zero) can never be selected.
module register_file_write_decoder #(
    parameter int ADDR_W = 5
) (
    input  logic                 en_i,
    input  logic [ADDR_W-1:0]    addr_i,
    output logic [2**ADDR_W-1:0] we_o
);

    always_comb begin
        we_o         = '0;
        we_o[addr_i] = en_i;
        we_o[0]      = 1'b0;
    end

endmodule

// File: rtl/register_file.sv
// Two-read, one-write register file; combinational reads with no write bypass.
module register_file
    import register_file_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    register_file_if.slave rf
);

    localparam int NREG = 2 ** ADDR_W;

    logic [NREG-1:0]   we_vec;
    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];

    register_file_write_decoder #(
        .ADDR_W (ADDR_W)
    ) u_write_decoder (
        .en_i   (rf.reg_write),
        .addr_i (rf.waddr),
        .we_o   (we_vec)
    );

    // Entry 0 is held at zero so it reduces to a constant.
    always_comb begin
        regs_d = regs_q;
        for (int i = 1; i < NREG; i++) begin
            if (we_vec[i]) begin
                regs_d[i] = rf.wdata;
            end
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NREG; i++) begin
            if (!rst_n_i) begin
                regs_q[i] <= '0;
            end else begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign rf.rdata1 = (rf.raddr1 == '0) ? '0 : regs_q[rf.raddr1];
    assign rf.rdata2 = (rf.raddr2 == '0) ? '0 : regs_q[rf.raddr2];

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: directed vector table, reset sweep and random traffic against a model.
module tb_register_file;
    import register_file_pkg::*;

    localparam int DW = DEF_DATA_W;
    localparam int AW = DEF_ADDR_W;

    logic clk;
    logic rst_n;

    register_file_if #(.DATA_W(DW), .ADDR_W(AW)) rf_if ();

    register_file #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .rf      (rf_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          rst_n;
        logic          we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic [AW-1:0] ra1;
        logic [AW-1:0] ra2;
        logic [DW-1:0] e1;
        logic [DW-1:0] e2;
    } vec_t;

    typedef struct {
        logic [DW-1:0] e1;
        logic [DW-1:0] e2;
    } exp_t;

    vec_t          vecs [15];
    exp_t          sb_q [$];
    logic [DW-1:0] model [32];
    int            n_vec = 0;
    int            n_err = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive after the falling edge, compare pre-edge reads, then take the rising edge.
    task automatic apply(input string name, input vec_t v);
        exp_t e;
        @(negedge clk);
        rst_n           = v.rst_n;
        rf_if.reg_write = v.we;
        rf_if.waddr     = v.wa;
        rf_if.wdata     = v.wd;
        rf_if.raddr1    = v.ra1;
        rf_if.raddr2    = v.ra2;
        sb_q.push_back('{e1: v.e1, e2: v.e2});
        #2;
        if (sb_q.size() == 0) begin
            check({name, " scoreboard empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check({name, " rdata1"}, rf_if.rdata1, e.e1);
            check({name, " rdata2"}, rf_if.rdata2, e.e2);
        end
        @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        //            rst   we    wa       wd             ra1      ra2       e1             e2
        vecs[0]  = '{1'b1, 1'b1, REG_T1,  32'hDEADBEEF, REG_T1,  REG_RA,   32'h0,         32'h0};
        vecs[1]  = '{1'b0, 1'b0, 5'd0,    32'h0,        REG_T1,  REG_RA,   32'hDEADBEEF,  32'h0};
        vecs[2]  = '{1'b1, 1'b0, 5'd0,    32'h0,        REG_T1,  REG_RA,   32'h0,         32'h0};
        vecs[3]  = '{1'b1, 1'b1, 5'b01001,32'h00001234, REG_T1,  REG_ZERO, 32'h0,         32'h0};
        vecs[4]  = '{1'b1, 1'b1, REG_ZERO,32'hFFFFFFFF, REG_T1,  REG_ZERO, 32'h00001234,  32'h0};
        vecs[5]  = '{1'b1, 1'b0, REG_T1,  32'hAAAA5555, REG_ZERO,REG_ZERO, 32'h0,         32'h0};
        vecs[6]  = '{1'b1, 1'b0, REG_T1,  32'hAAAA5555, REG_T1,  REG_T1,   32'h00001234,  32'h00001234};
        vecs[7]  = '{1'b1, 1'b0, REG_T1,  32'hAAAA5555, REG_T1,  REG_ZERO, 32'h00001234,  32'h0};
        vecs[8]  = '{1'b1, 1'b1, REG_T1,  32'h1,        REG_T1,  REG_T1,   32'h00001234,  32'h00001234};
        vecs[9]  = '{1'b1, 1'b1, REG_T1,  32'h2,        REG_T1,  REG_T1,   32'h1,         32'h1};
        vecs[10] = '{1'b1, 1'b0, REG_T1,  32'h0,        REG_T1,  REG_T1,   32'h2,         32'h2};
        vecs[11] = '{1'b1, 1'b1, REG_RA,  32'h12345678, REG_RA,  REG_T1,   32'h0,         32'h2};
        vecs[12] = '{1'b1, 1'b1, 5'd5,    32'h0000CAFE, REG_RA,  5'd5,     32'h12345678,  32'h0};
        vecs[13] = '{1'b0, 1'b1, REG_RA,  32'h00400008, REG_RA,  5'd5,     32'h12345678,  32'h0000CAFE};
        vecs[14] = '{1'b1, 1'b0, REG_RA,  32'h0,        REG_RA,  5'd5,     32'h0,         32'h0};

        rst_n           = 1'b0;
        rf_if.reg_write = 1'b0;
        rf_if.waddr     = '0;
        rf_if.wdata     = '0;
        rf_if.raddr1    = '0;
        rf_if.raddr2    = '0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 15; i++) begin
            apply($sformatf("vec%0d", i), vecs[i]);
        end

        // Post-reset sweep: every writable register reads zero on both ports.
        for (int r = 1; r < 32; r++) begin
            v = '{1'b1, 1'b0, 5'd0, 32'h0, 5'(r), 5'(32 - r), 32'h0, 32'h0};
            apply($sformatf("sweep%0d", r), v);
        end

        // Disabled write with undriven data leaves contents alone.
        @(negedge clk);
        rf_if.reg_write = 1'b0;
        rf_if.waddr     = REG_SP;
        rf_if.wdata     = 'x;
        @(posedge clk);
        v = '{1'b1, 1'b0, 5'd0, 32'h0, REG_SP, REG_V0, 32'h0, 32'h0};
        apply("xdata", v);

        // Back-to-back writes to one register: last value wins per edge.
        v = '{1'b1, 1'b1, REG_AT, 32'h11111111, REG_AT, REG_AT, 32'h0, 32'h0};
        apply("b2b0", v);
        v = '{1'b1, 1'b1, REG_AT, 32'h22222222, REG_AT, REG_AT, 32'h11111111, 32'h11111111};
        apply("b2b1", v);
        v = '{1'b1, 1'b0, REG_AT, 32'h0, REG_AT, REG_ZERO, 32'h22222222, 32'h0};
        apply("b2b2", v);

        for (int r = 0; r < 32; r++) model[r] = '0;
        model[1] = 32'h22222222;

        // Random traffic against a reference array.
        for (int n = 0; n < 200; n++) begin
            v.rst_n = 1'b1;
            v.we    = 1'($urandom_range(0, 3) != 0);
            v.wa    = 5'($urandom_range(0, 31));
            v.wd    = 32'($urandom);
            v.ra1   = 5'($urandom_range(0, 31));
            v.ra2   = (n % 4 == 0) ? v.wa : 5'($urandom_range(0, 31));
            v.e1    = model[v.ra1];
            v.e2    = model[v.ra2];
            apply($sformatf("rand%0d", n), v);
            if (v.we && v.wa != 5'd0) model[v.wa] = v.wd;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/register_file.md
# register_file

Two-read, one-write register file for the single-cycle processor datapath. It is the consumer of the 5-bit write-register select produced by the destination multiplexer (rt vs rd). It decodes that 5-bit address into one-hot write enables and commits write-back data on the clock edge. It also serves the rs/rt operand reads combinationally within the same cycle.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; register count is 2**ADDR_W (32)

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  reset, synchronous, active-low; one clock, synchronous active-low reset, sampled on rising edge of clk
- reg_write  input  1  write enable from control unit
- waddr  input  ADDR_W  write register number (output of destination mux)
- wdata  input  DATA_W  write-back data
- raddr1  input  ADDR_W  read port 1 register number (rs)
- raddr2  input  ADDR_W  read port 2 register number (rt)
- rdata1  output  DATA_W  read port 1 data
- rdata2  output  DATA_W  read port 2 data

## Operation
- Storage: 32 x DATA_W flops, regs[0..31].
- Reset: rising clk with rst_n=0 clears regs[1..31] to 0. Reset takes priority over a simultaneous write, so a write in the reset cycle is dropped.
- Write decode: waddr is decoded to a 32-bit one-hot vector we_vec. It is gated by reg_write; bit 0 is forced to 0.
- Write: rising clk, rst_n=1, reg_write=1, waddr!=0 gives regs[waddr] <= wdata. Writes to waddr=0 are discarded.
- reg_write=0 gives no register changes, regardless of waddr/wdata (including X on wdata).
- Register 0 ($zero): not stored, or stored constant. Reads of address 0 always return 0.
- Reads: rdataN = (raddrN==0) ? 0 : regs[raddrN]. Purely combinational from raddrN and current contents.
- Both read ports are independent. Both may address the same register, and either may equal waddr.
- Read-during-write: no bypass.
  - Within the write cycle, rdataN returns the pre-edge value.
  - The new value appears after the rising edge.
  - This matches the single-cycle model: write-back completes at end of cycle.
- Reset mid-operation: a pending write in the reset cycle is lost. Contents are 0 from the next cycle; reads show 0 after the edge.

## Timing
- Write latency: data visible on rdataN one edge after the write cycle, i.e. the combinational read settles after the edge that commits.
- Read latency: 0 cycles (combinational), address-to-data path through a 32:1 mux per port.
- Reset value of outputs: rdata1=rdata2=0 for every address after a reset edge until the first write.
- No handshake; reg_write is a level enable sampled at each edge. Back-to-back writes to the same register each cycle: last written value wins per edge.
- Simultaneous write and read of the same address: old data this cycle, new data next cycle.

## Structure
- Shared processor package holds:
  - DATA_W/ADDR_W defaults
  - REG_ZERO = 5'd0
  - named register constants used by control and testbenches (e.g. REG_RA = 5'd31 for jal)
- Sub-module write_decoder: ADDR_W-to-2**ADDR_W one-hot decoder with enable input (reg_write) and bit 0 masked.
  - It is the inverse of the select path in MUX5b.
  - It is reused by any future multi-port or banked file.
- Read muxing stays inline in register_file; no separate module.

## Test plan
- Reset: hold rst_n=0 one edge after writing regs[9]=32'hDEADBEEF, then release -> rdata1 at raddr1=9 reads 0; rdata2 at raddr2=31 reads 0.
- Basic write/read:
  - reg_write=1, waddr=5'b01001, wdata=32'h0000_1234, one edge -> raddr1=9 gives 32'h0000_1234.
  - raddr2=0 gives 0.
- $zero protection: reg_write=1, waddr=0, wdata=32'hFFFF_FFFF, one edge -> raddr1=0 and raddr2=0 both read 0.
- Enable gating: reg_write=0, waddr=9, wdata=32'hAAAA_5555 for 3 edges -> regs[9] remains 32'h0000_1234.
- Read-during-write: regs[9]=32'h1; drive reg_write=1, waddr=9, wdata=32'h2, raddr1=raddr2=9 -> 32'h1 before the edge, 32'h2 after.
- Reset priority: rst_n=0 with reg_write=1, waddr=31, wdata=32'h0040_0008 -> regs[31] reads 0 after the edge; all 31 writable registers read 0 in a full sweep.
